// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz VGA raster timing with a pixel-rate divider, drawer coordinate outputs and a
// registered, blank-gated RGB/sync output stage aligned to one pixel of latency.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] counterX,
  output logic [9:0] counterY,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_start,
  input  logic [7:0] R_in,
  input  logic [7:0] G_in,
  input  logic [7:0] B_in,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk_en
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [9:0] HLast   = 10'(HTotal - 1);
  localparam logic [9:0] VLast   = 10'(VTotal - 1);
  localparam logic [9:0] HAct    = 10'(H_ACTIVE);
  localparam logic [9:0] VAct    = 10'(V_ACTIVE);
  localparam logic [9:0] HsStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HsEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VsStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VsEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic            wrap_q, wrap_d;
  logic            tick, von, hs_raw, vs_raw;

  logic [7:0]      r_q, g_q, b_q;
  logic            hs_q, vs_q, blank_n_q;

  assign tick   = (div_q == DivLast);
  assign von    = (x_q < HAct) && (y_q < VAct);
  assign hs_raw = !((x_q >= HsStart) && (x_q < HsEnd));
  assign vs_raw = !((y_q >= VsStart) && (y_q < VsEnd));

  always_comb begin
    div_d  = tick ? '0 : div_q + 1'b1;
    x_d    = x_q;
    y_d    = y_q;
    wrap_d = 1'b0;
    if (tick) begin
      if (x_q == HLast) begin
        x_d = '0;
        if (y_q == VLast) begin
          y_d    = '0;
          wrap_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // wrap_q marks only the (0,0) reached by wrapping, never the one entered through reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      x_q    <= x_d;
      y_q    <= y_d;
      wrap_q <= wrap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else if (tick) begin
      r_q       <= von ? R_in : 8'h00;
      g_q       <= von ? G_in : 8'h00;
      b_q       <= von ? B_in : 8'h00;
      hs_q      <= hs_raw;
      vs_q      <= vs_raw;
      blank_n_q <= von;
    end
  end

  assign counterX    = x_q;
  assign counterY    = y_q;
  assign video_on    = von;
  assign pixel_tick  = tick;
  assign frame_start = wrap_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign vga_clk_en  = tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench: a full-size CLK_DIV=2 instance and a miniature CLK_DIV=1 instance, both
// checked every cycle against an arithmetic model derived from the count of edges since reset.
module tb_vga_timing_gen;

  // Miniature geometry so that many whole frames fit in a short run.
  localparam int BHA = 20, BHF = 3, BHS = 5, BHB = 4;
  localparam int BVA = 12, BVF = 2, BVS = 2, BVB = 3;

  localparam int P_D  [2] = '{2, 1};
  localparam int P_HA [2] = '{640, BHA};
  localparam int P_HF [2] = '{16, BHF};
  localparam int P_HS [2] = '{96, BHS};
  localparam int P_HB [2] = '{48, BHB};
  localparam int P_VA [2] = '{480, BVA};
  localparam int P_VF [2] = '{10, BVF};
  localparam int P_VS [2] = '{2, BVS};
  localparam int P_VB [2] = '{33, BVB};

  localparam int NumCycles = 20000;

  logic       clk;
  logic       rst_a, rst_b;
  logic [7:0] r_in, g_in, b_in;

  logic [9:0] cx_a, cy_a, cx_b, cy_b;
  logic       von_a, tick_a, fs_a, von_b, tick_b, fs_b;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic       hs_a, vs_a, bn_a, sn_a, ce_a, hs_b, vs_b, bn_b, sn_b, ce_b;

  vga_timing_gen #(
    .CLK_DIV (2),
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2),  .V_BP(33)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_a), .counterX(cx_a), .counterY(cy_a), .video_on(von_a),
    .pixel_tick(tick_a), .frame_start(fs_a), .R_in(r_in), .G_in(g_in), .B_in(b_in),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hs(hs_a), .vga_vs(vs_a),
    .vga_blank_n(bn_a), .vga_sync_n(sn_a), .vga_clk_en(ce_a)
  );

  vga_timing_gen #(
    .CLK_DIV (1),
    .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_b), .counterX(cx_b), .counterY(cy_b), .video_on(von_b),
    .pixel_tick(tick_b), .frame_start(fs_b), .R_in(r_in), .G_in(g_in), .B_in(b_in),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hs(hs_b), .vga_vs(vs_b),
    .vga_blank_n(bn_b), .vga_sync_n(sn_b), .vga_clk_en(ce_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model state: edges since reset, plus the pixel captured at the last tick edge.
  int          md_c    [2];
  bit          md_have [2];
  int          md_cx   [2];
  int          md_cy   [2];
  logic [23:0] md_rgb  [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int ht(input int i);
    return P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
  endfunction

  function automatic int vt(input int i);
    return P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
  endfunction

  task automatic md_step(input int i, input bit rst_n);
    int k;
    if (!rst_n) begin
      md_c[i]    = 0;
      md_have[i] = 1'b0;
    end else begin
      if (md_c[i] % P_D[i] == P_D[i] - 1) begin
        k          = md_c[i] / P_D[i];
        md_have[i] = 1'b1;
        md_cx[i]   = k % ht(i);
        md_cy[i]   = (k / ht(i)) % vt(i);
        md_rgb[i]  = {r_in, g_in, b_in};
      end
      md_c[i]++;
    end
  endtask

  task automatic check_dut(input int i);
    int k, x, y, cvon;
    int e_r, e_g, e_b, e_hs, e_vs, e_bn, e_fs;
    logic [9:0] ox, oy;
    logic [7:0] or_, og, ob;
    logic ovon, otick, ofs, ohs, ovs, obn, osn, oce;
    string p;
    p = (i == 0) ? "a" : "b";
    if (i == 0) begin
      ox = cx_a; oy = cy_a; ovon = von_a; otick = tick_a; ofs = fs_a;
      or_ = r_a; og = g_a; ob = b_a; ohs = hs_a; ovs = vs_a; obn = bn_a; osn = sn_a; oce = ce_a;
    end else begin
      ox = cx_b; oy = cy_b; ovon = von_b; otick = tick_b; ofs = fs_b;
      or_ = r_b; og = g_b; ob = b_b; ohs = hs_b; ovs = vs_b; obn = bn_b; osn = sn_b; oce = ce_b;
    end
    k    = md_c[i] / P_D[i];
    x    = k % ht(i);
    y    = (k / ht(i)) % vt(i);
    e_fs = (md_c[i] % P_D[i] == 0 && k > 0 && k % (ht(i) * vt(i)) == 0) ? 1 : 0;
    if (md_have[i]) begin
      cvon = (md_cx[i] < P_HA[i] && md_cy[i] < P_VA[i]) ? 1 : 0;
      e_r  = cvon ? int'(md_rgb[i][23:16]) : 0;
      e_g  = cvon ? int'(md_rgb[i][15:8]) : 0;
      e_b  = cvon ? int'(md_rgb[i][7:0]) : 0;
      e_hs = (md_cx[i] >= P_HA[i] + P_HF[i] && md_cx[i] < P_HA[i] + P_HF[i] + P_HS[i]) ? 0 : 1;
      e_vs = (md_cy[i] >= P_VA[i] + P_VF[i] && md_cy[i] < P_VA[i] + P_VF[i] + P_VS[i]) ? 0 : 1;
      e_bn = cvon;
    end else begin
      e_r = 0; e_g = 0; e_b = 0; e_hs = 1; e_vs = 1; e_bn = 0;
    end
    check_eq({p, ".counterX"}, 32'(ox), x);
    check_eq({p, ".counterY"}, 32'(oy), y);
    check_eq({p, ".video_on"}, 32'(ovon), (x < P_HA[i] && y < P_VA[i]) ? 1 : 0);
    check_eq({p, ".pixel_tick"}, 32'(otick), (md_c[i] % P_D[i] == P_D[i] - 1) ? 1 : 0);
    check_eq({p, ".vga_clk_en"}, 32'(oce), (md_c[i] % P_D[i] == P_D[i] - 1) ? 1 : 0);
    check_eq({p, ".frame_start"}, 32'(ofs), e_fs);
    check_eq({p, ".vga_r"}, 32'(or_), e_r);
    check_eq({p, ".vga_g"}, 32'(og), e_g);
    check_eq({p, ".vga_b"}, 32'(ob), e_b);
    check_eq({p, ".vga_hs"}, 32'(ohs), e_hs);
    check_eq({p, ".vga_vs"}, 32'(ovs), e_vs);
    check_eq({p, ".vga_blank_n"}, 32'(obn), e_bn);
    check_eq({p, ".vga_sync_n"}, 32'(osn), 0);
  endtask

  initial begin
    int  last_fs_b, hs_cnt_a, vs_cnt_b, k;
    bit  done_a, done_b;
    last_fs_b = -1;
    hs_cnt_a  = 0;
    vs_cnt_b  = 0;
    done_a    = 1'b0;
    done_b    = 1'b0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    r_in  = 8'h00;
    g_in  = 8'h00;
    b_in  = 8'h00;
    md_step(0, rst_a);
    md_step(1, rst_b);

    while (cyc < NumCycles) begin
      @(negedge clk);
      cyc++;
      check_dut(0);
      check_dut(1);

      // Frame period of the CLK_DIV=1 instance: V_TOTAL*H_TOTAL clocks between pulses.
      if (fs_b === 1'b1) begin
        if (last_fs_b >= 0) check_eq("b.frame_period", 32'(cyc - last_fs_b), ht(1) * vt(1));
        last_fs_b = cyc;
      end
      if (hs_a === 1'b0) hs_cnt_a++;
      else if (hs_cnt_a > 0) begin
        check_eq("a.hs_low_clks", 32'(hs_cnt_a), P_HS[0] * P_D[0]);
        hs_cnt_a = 0;
      end
      if (vs_b === 1'b0) vs_cnt_b++;
      else if (vs_cnt_b > 0) begin
        check_eq("b.vs_low_clks", 32'(vs_cnt_b), P_VS[1] * ht(1));
        vs_cnt_b = 0;
      end

      rst_a = 1'b1;
      rst_b = 1'b1;
      if (cyc < 5) begin
        rst_a = 1'b0;
        rst_b = 1'b0;
      end
      k = md_c[0] / P_D[0];
      if (!done_a && k % ht(0) == 300 && k / ht(0) == 3) begin
        rst_a  = 1'b0;
        done_a = 1'b1;
      end
      k = md_c[1] / P_D[1];
      if (!done_b && k / (ht(1) * vt(1)) >= 2 && k % ht(1) == 17 && (k / ht(1)) % vt(1) == 7) begin
        rst_b  = 1'b0;
        done_b = 1'b1;
      end
      if (cyc > 4000 && $urandom_range(0, 2999) == 0) rst_b = 1'b0;
      if (!rst_b) begin
        last_fs_b = -1;
        vs_cnt_b  = 0;
      end

      if ((cyc / 3000) % 2 == 1) begin
        r_in = 8'hE5;
        g_in = 8'h9C;
        b_in = 8'h14;
      end else begin
        r_in = 8'($urandom);
        g_in = 8'($urandom);
        b_in = 8'($urandom);
      end

      md_step(0, rst_a);
      md_step(1, rst_b);
    end

    check_eq("a.mid_reset_done", 32'(done_a), 1);
    check_eq("b.mid_reset_done", 32'(done_b), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Upstream VGA stage of the battleship display path: generates 640x480@60 Hz raster timing from the system clock and supplies the `counterX`/`counterY` pixel coordinates consumed by the board/matrix drawers. It also samples the drawers' combinational RGB for the current coordinate and drives registered, blank-gated RGB and sync signals to the VGA DAC. Sync and RGB leave the block with identical latency.

## Interface
- `CLK_DIV`, 2: system clocks per pixel; 50 MHz in gives a 25 MHz pixel rate. Must be ≥1.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `rst_n` in 1: synchronous reset, active low.
- `counterX` out 10: current pixel column, 0..H_TOTAL-1.
- `counterY` out 10: current line, 0..V_TOTAL-1.
- `video_on` out 1: high when counterX < H_ACTIVE and counterY < V_ACTIVE.
- `pixel_tick` out 1: one-clk strobe; the counters advance on the edge that ends this cycle.
- `frame_start` out 1: one-clk pulse in the first cycle the counters read (0,0) after a wrap.
- `R_in`, `G_in`, `B_in` in 8 each: drawer colour for the current (counterX, counterY).
- `vga_r`, `vga_g`, `vga_b` out 8 each: registered colour to the DAC.
- `vga_hs`, `vga_vs` out 1 each: registered syncs, active low.
- `vga_blank_n` out 1: registered `video_on`.
- `vga_sync_n` out 1: tied to 0.
- `vga_clk_en` out 1: equal to `pixel_tick`, for DAC clock gating.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800. V_TOTAL = 525.
- Divider counts 0..CLK_DIV-1 and wraps. `pixel_tick` = (div == CLK_DIV-1). If CLK_DIV=1, `pixel_tick` is constantly high.
- On a clk edge with `pixel_tick` high:
  - counterX increments.
  - At H_TOTAL-1, counterX wraps to 0 and counterY increments.
  - When counterY is also at V_TOTAL-1, counterY wraps to 0.
- Counters never change on an edge without `pixel_tick`.
- Raw hsync is low for counterX in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
- Raw vsync is low for counterY in [490,491], for the whole of each of those lines.
- `video_on` and `frame_start` are decoded from the counter registers and are valid in the same cycle as the counters.
- Output stage, on each `pixel_tick` edge, captures:
  - `vga_r/g/b` = `video_on` ? `R/G/B_in` : 0
  - `vga_hs/vga_vs` = raw syncs
  - `vga_blank_n` = `video_on`
  
  Outputs hold between ticks.
- RGB outside the active area is forced to 0 regardless of `R/G/B_in`.

Reset: while `rst_n`=0 at a clk edge:
- div=0, counterX=0, counterY=0.
- `vga_r/g/b`=0, `vga_hs`=1, `vga_vs`=1, `vga_blank_n`=0.
- `frame_start` is not asserted for the (0,0) state entered through reset.

Reset mid-frame forces the above on the next edge. The first `pixel_tick` occurs CLK_DIV-1 cycles after release.

## Timing
- Counter-to-output latency: exactly one pixel (one `pixel_tick` edge) for RGB, syncs and blank alike. Sync and RGB stay mutually aligned.
- The drawer path is combinational. `R/G/B_in` must settle within one clk of a counter change; they are sampled only on tick edges.
- With CLK_DIV=2: counterX holds each value for 2 clks; line = 1600 clks; frame = 840 000 clks.
- `frame_start` is high for exactly one clk per frame: the clk after the (799,524)→(0,0) edge.
- `vga_hs` low width = 96 ticks. `vga_vs` low width = 2 lines = 1600 ticks.

## Test plan
- Reset/startup, CLK_DIV=2, hold `rst_n`=0 for 5 clks then release:
  - all reset values hold during reset;
  - first `pixel_tick` at clk 1 after release;
  - counterX=1 at clk 2.
- Line wrap:
  - counterX sequence 798→799→0, with counterY 0→1 on the same edge;
  - `vga_hs` falls one tick after counterX reaches 656 and rises one tick after it reaches 752 (96 ticks low).
- Frame wrap:
  - (799,524)→(0,0) raises `frame_start` for exactly 1 clk;
  - frame period is 840 000 clks;
  - `vga_vs` is low for 1600 ticks, starting one tick after (0,490).
- Blanking: drive `R/G/B_in`=8'hE5/8'h9C/8'h14 constantly.
  - `vga_r/g/b` show that colour only for captured coordinates with X<640 and Y<480, else 0;
  - `vga_blank_n` matches `vga_r`≠0 at every tick.
- Mid-frame reset: assert `rst_n`=0 for 1 clk at (300,200).
  - Next edge gives counters (0,0), `vga_hs`=`vga_vs`=1, RGB=0, and no `frame_start`;
  - normal counting resumes afterwards.
- CLK_DIV=1 build: `pixel_tick` constantly 1; counterX increments every clk; frame = 420 000 clks.
